id_ex_operand_stage: RTL and testbench
======================================

# id_ex_operand_stage

ID/EX pipeline register and operand-select stage that sits directly upstream of the 32-bit ALU. It latches decoded control and register operands each cycle. It resolves data hazards by forwarding from EX/MEM and MEM/WB. It presents final `A`, `B` and `ALUControl` to the ALU. It also detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

## Interface
Parameters:
- `DATA_W`, 32: operand width.
- `CTRL_W`, 6: ALU control width.

Ports:
- `Clk` in 1: clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Stall` in 1: downstream hold; the stage keeps its contents.
- `Flush` in 1: branch or jump squash; a bubble is loaded.
- `In_Valid` in 1: the decode slot holds a real instruction.
- `In_ALUControl` in 6: decoded ALU operation.
- `In_ALUSrc` in 1: 1 selects `In_Imm` for `B`.
- `In_RegWrite`, `In_MemRead`, `In_MemWrite`, `In_MemToReg` in 1 each: control bits carried forward.
- `In_Rs`, `In_Rt`, `In_WriteReg` in 5 each: source and destination register numbers.
- `In_RsData`, `In_RtData` in 32 each: register-file read data.
- `In_Imm` in 32: immediate, already extended by decode.
- `In_Shamt` in 5: shift amount field.
- `ExMem_RegWrite` in 1, `ExMem_WriteReg` in 5, `ExMem_Result` in 32: EX/MEM forwarding source.
- `MemWb_RegWrite` in 1, `MemWb_WriteReg` in 5, `MemWb_Result` in 32: MEM/WB forwarding source.
- `Out_Valid` out 1.
- `ALUControl` out 6, `A` out 32, `B` out 32: these drive the ALU.
- `Out_StoreData` out 32: forwarded rt value, used for SW.
- `Out_WriteReg` out 5.
- `Out_RegWrite`, `Out_MemRead`, `Out_MemWrite`, `Out_MemToReg` out 1 each.
- `Hazard` out 1: load-use detected. Upstream holds PC and IF/ID while this is high.

## Operation
- Registered state per cycle:
  - valid
  - all control bits
  - `Rs`, `Rt`, `WriteReg`
  - `RsData`, `RtData`
  - `Imm`, `Shamt`
- Update priority on each rising edge:
  - `Reset`: bubble.
  - else `Flush`: bubble.
  - else `Stall`: hold.
  - else `Hazard`: bubble.
  - else load the `In_*` signals.
- Bubble contents:
  - valid = 0.
  - `RegWrite`, `MemRead`, `MemWrite`, `MemToReg` = 0.
  - `ALUControl` = `6'b000000` (AND).
  - All data fields = 0.
- Forwarding for each registered source `r` (`Rs` or `Rt`), in priority order:
  - If `ExMem_RegWrite`, `ExMem_WriteReg == r` and `r != 0`: use `ExMem_Result`.
  - Else if the same conditions hold for MEM/WB: use `MemWb_Result`.
  - Else use the registered data.
- Register 0 is never forwarded.
- During `Stall`, the held `RsData` and `RtData` are rewritten with their forwarded values. A result that leaves MEM/WB mid-stall is therefore not lost.
- `A` selection:
  - `ALUControl` ∈ {SLL 8, SRL 9, SRA 11}: `{27'b0, Shamt}`.
  - Otherwise: forwarded rs.
  - Variable shifts (16, 17, 18) use forwarded rs.
- `B` = `ALUSrc ? Imm : forwarded rt`.
- `Out_StoreData` = forwarded rt, regardless of `ALUSrc`.
- `Hazard` is high when all of the following hold:
  - `In_Valid`
  - registered valid
  - registered `MemRead`
  - registered `WriteReg != 0`
  - registered `WriteReg` equals `In_Rs` or `In_Rt`
- `Hazard` is combinational and is not gated by `Stall`.

## Timing
- One-cycle latency from `In_*` to the registered outputs.
- `A`, `B` and `Out_StoreData` are combinational from the registered state plus the forwarding inputs, so they are valid in the same cycle as EX.
- Reset value of every output is 0 (`ALUControl` = `6'b000000`, `Out_Valid` = 0). `Hazard` is 0 after reset because registered valid is 0.
- Reset mid-stall or mid-hazard: a bubble is loaded on the next edge and nothing is held.
- `Flush` together with `Stall`: flush wins.
- `Flush` together with `Hazard`: a bubble is loaded, and `Hazard` clears once the load has drained.
- A load-use pair costs exactly one bubble:
  - Cycle n: `Hazard` = 1.
  - Edge n+1: a bubble is loaded.
  - Cycle n+1: the consumer is still at the input with `Hazard` = 0, because the load now occupies EX/MEM.
  - Edge n+2: the consumer loads. Its operand later comes from MEM/WB forwarding.

## Structure
- Shared package `mips_pkg`:
  - ALU control constants: `ALU_AND`=0, `ALU_SLL`=8, `ALU_SRL`=9, `ALU_SRA`=11, `ALU_SLLV`=16, `ALU_SRLV`=17, `ALU_SRAV`=18, `ALU_LUI`=38.
  - `REG_ZERO`.
  - The bubble constant.
- One sub-module, `operand_forward_mux`:
  - Inputs: `r`, registered data, EX/MEM triple, MEM/WB triple.
  - Output: resolved value.
  - Instantiated twice, for rs and rt.

## Test plan
- **Basic load, no hazards.** Stimulus: load ADD with rs=$8 (data 5), rt=$9 (data 7). Required response: next cycle `A`=5, `B`=7, `ALUControl`=2, `Out_Valid`=1.
- **Forwarding priority.** Stimulus: held rs=$8; `ExMem_WriteReg`=$8 with result 0x11; `MemWb_WriteReg`=$8 with result 0x22. Required response: `A`=0x11. After dropping EX/MEM: `A`=0x22.
- **Register 0 never forwarded.** Stimulus: rs=$0, `ExMem_WriteReg`=0, `ExMem_RegWrite`=1, result 0xFF. Required response: `A`=0.
- **Load-use hazard.** Stimulus: LW writing $3, followed by `In_Rt`=$3. Required response: `Hazard`=1 for one cycle, one bubble with `Out_Valid`=0 and `Out_RegWrite`=0, then the consumer loads.
- **Shamt select and stall refresh.** Part 1: SLL with shamt 4 gives `A`=4. Part 2: hold `Stall` for 3 cycles while `MemWb` writes the held rt once. Required response: `B` keeps the forwarded value after `MemWb` deasserts.
- **Flush/Stall interaction and reset.** Part 1: `Flush`+`Stall` in the same cycle gives a bubble. Part 2: `Reset` mid-stall gives all outputs 0 on the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control encodings, register-zero
// and the ID/EX control-bundle bubble.
package mips_pkg;

  localparam logic [5:0] ALU_AND  = 6'd0;
  localparam logic [5:0] ALU_SLL  = 6'd8;
  localparam logic [5:0] ALU_SRL  = 6'd9;
  localparam logic [5:0] ALU_SRA  = 6'd11;
  localparam logic [5:0] ALU_SLLV = 6'd16;
  localparam logic [5:0] ALU_SRLV = 6'd17;
  localparam logic [5:0] ALU_SRAV = 6'd18;
  localparam logic [5:0] ALU_LUI  = 6'd38;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] write_reg;
    logic [4:0] shamt;
  } id_ex_ctl_t;

  // A bubble is an all-zero bundle: not valid, no side effects, no registers.
  localparam id_ex_ctl_t ID_EX_BUBBLE = '0;

  // Immediate shifts take their amount from the shamt field instead of rs.
  function automatic logic is_shamt_op(input logic [5:0] ctl);
    return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
  endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Resolves one source register against the EX/MEM and MEM/WB results,
// with EX/MEM taking priority and register zero never forwarded.
module operand_forward_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        r,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_regwrite,
  input  logic [4:0]        exmem_writereg,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [4:0]        memwb_writereg,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] value
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_regwrite && (exmem_writereg == r) && (r != REG_ZERO);
  assign memwb_hit = memwb_regwrite && (memwb_writereg == r) && (r != REG_ZERO);

  always_comb begin
    value = reg_data;
    if (exmem_hit) begin
      value = exmem_result;
    end else if (memwb_hit) begin
      value = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble
// insertion and stall/flush handling, feeding the ALU directly.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              In_Valid,
  input  logic [CTRL_W-1:0] In_ALUControl,
  input  logic              In_ALUSrc,
  input  logic              In_RegWrite,
  input  logic              In_MemRead,
  input  logic              In_MemWrite,
  input  logic              In_MemToReg,
  input  logic [4:0]        In_Rs,
  input  logic [4:0]        In_Rt,
  input  logic [4:0]        In_WriteReg,
  input  logic [DATA_W-1:0] In_RsData,
  input  logic [DATA_W-1:0] In_RtData,
  input  logic [DATA_W-1:0] In_Imm,
  input  logic [4:0]        In_Shamt,
  input  logic              ExMem_RegWrite,
  input  logic [4:0]        ExMem_WriteReg,
  input  logic [DATA_W-1:0] ExMem_Result,
  input  logic              MemWb_RegWrite,
  input  logic [4:0]        MemWb_WriteReg,
  input  logic [DATA_W-1:0] MemWb_Result,
  output logic              Out_Valid,
  output logic [CTRL_W-1:0] ALUControl,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Out_StoreData,
  output logic [4:0]        Out_WriteReg,
  output logic              Out_RegWrite,
  output logic              Out_MemRead,
  output logic              Out_MemWrite,
  output logic              Out_MemToReg,
  output logic              Hazard
);

  // Flow control: a slot advances on every edge unless Stall holds it;
  // Flush and a load-use Hazard replace the incoming slot with a bubble.
  id_ex_ctl_t        ctl_q;
  logic [CTRL_W-1:0] alu_ctl_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  assign Hazard = In_Valid && ctl_q.valid && ctl_q.mem_read &&
                  (ctl_q.write_reg != REG_ZERO) &&
                  ((ctl_q.write_reg == In_Rs) || (ctl_q.write_reg == In_Rt));

  always_ff @(posedge Clk) begin
    if (Reset || Flush || (!Stall && Hazard)) begin
      ctl_q     <= ID_EX_BUBBLE;
      alu_ctl_q <= CTRL_W'(ALU_AND);
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else if (Stall) begin
      // Capture forwarded values so a result retiring mid-stall survives.
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
    end else begin
      ctl_q.valid      <= In_Valid;
      ctl_q.alu_src    <= In_ALUSrc;
      ctl_q.reg_write  <= In_RegWrite;
      ctl_q.mem_read   <= In_MemRead;
      ctl_q.mem_write  <= In_MemWrite;
      ctl_q.mem_to_reg <= In_MemToReg;
      ctl_q.rs         <= In_Rs;
      ctl_q.rt         <= In_Rt;
      ctl_q.write_reg  <= In_WriteReg;
      ctl_q.shamt      <= In_Shamt;
      alu_ctl_q        <= In_ALUControl;
      rs_data_q        <= In_RsData;
      rt_data_q        <= In_RtData;
      imm_q            <= In_Imm;
    end
  end

  operand_forward_mux #(.DATA_W(DATA_W)) u_fwd_rs (
    .r              (ctl_q.rs),
    .reg_data       (rs_data_q),
    .exmem_regwrite (ExMem_RegWrite),
    .exmem_writereg (ExMem_WriteReg),
    .exmem_result   (ExMem_Result),
    .memwb_regwrite (MemWb_RegWrite),
    .memwb_writereg (MemWb_WriteReg),
    .memwb_result   (MemWb_Result),
    .value          (fwd_rs)
  );

  operand_forward_mux #(.DATA_W(DATA_W)) u_fwd_rt (
    .r              (ctl_q.rt),
    .reg_data       (rt_data_q),
    .exmem_regwrite (ExMem_RegWrite),
    .exmem_writereg (ExMem_WriteReg),
    .exmem_result   (ExMem_Result),
    .memwb_regwrite (MemWb_RegWrite),
    .memwb_writereg (MemWb_WriteReg),
    .memwb_result   (MemWb_Result),
    .value          (fwd_rt)
  );

  assign A             = is_shamt_op(6'(alu_ctl_q)) ?
                         {{(DATA_W-5){1'b0}}, ctl_q.shamt} : fwd_rs;
  assign B             = ctl_q.alu_src ? imm_q : fwd_rt;
  assign Out_StoreData = fwd_rt;
  assign Out_Valid     = ctl_q.valid;
  assign ALUControl    = alu_ctl_q;
  assign Out_WriteReg  = ctl_q.write_reg;
  assign Out_RegWrite  = ctl_q.reg_write;
  assign Out_MemRead   = ctl_q.mem_read;
  assign Out_MemWrite  = ctl_q.mem_write;
  assign Out_MemToReg  = ctl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expectations are queued when
// stimulus is applied and popped against the DUT outputs.
module tb_id_ex_operand_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, In_Valid;
  logic [5:0]  In_ALUControl;
  logic        In_ALUSrc, In_RegWrite, In_MemRead, In_MemWrite, In_MemToReg;
  logic [4:0]  In_Rs, In_Rt, In_WriteReg, In_Shamt;
  logic [31:0] In_RsData, In_RtData, In_Imm;
  logic        ExMem_RegWrite, MemWb_RegWrite;
  logic [4:0]  ExMem_WriteReg, MemWb_WriteReg;
  logic [31:0] ExMem_Result, MemWb_Result;
  logic        Out_Valid, Out_RegWrite, Out_MemRead, Out_MemWrite, Out_MemToReg, Hazard;
  logic [5:0]  ALUControl;
  logic [31:0] A, B, Out_StoreData;
  logic [4:0]  Out_WriteReg;

  logic [31:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;

  id_ex_operand_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .In_Valid(In_Valid),
    .In_ALUControl(In_ALUControl), .In_ALUSrc(In_ALUSrc), .In_RegWrite(In_RegWrite),
    .In_MemRead(In_MemRead), .In_MemWrite(In_MemWrite), .In_MemToReg(In_MemToReg),
    .In_Rs(In_Rs), .In_Rt(In_Rt), .In_WriteReg(In_WriteReg), .In_RsData(In_RsData),
    .In_RtData(In_RtData), .In_Imm(In_Imm), .In_Shamt(In_Shamt),
    .ExMem_RegWrite(ExMem_RegWrite), .ExMem_WriteReg(ExMem_WriteReg), .ExMem_Result(ExMem_Result),
    .MemWb_RegWrite(MemWb_RegWrite), .MemWb_WriteReg(MemWb_WriteReg), .MemWb_Result(MemWb_Result),
    .Out_Valid(Out_Valid), .ALUControl(ALUControl), .A(A), .B(B), .Out_StoreData(Out_StoreData),
    .Out_WriteReg(Out_WriteReg), .Out_RegWrite(Out_RegWrite), .Out_MemRead(Out_MemRead),
    .Out_MemWrite(Out_MemWrite), .Out_MemToReg(Out_MemToReg), .Hazard(Hazard)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // drivers
  task automatic drive_instr(input logic v, input logic [5:0] ctl, input logic alusrc,
                             input logic rw, input logic mr, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] wr,
                             input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [31:0] imm, input logic [4:0] sh);
    In_Valid = v; In_ALUControl = ctl; In_ALUSrc = alusrc; In_RegWrite = rw;
    In_MemRead = mr; In_MemWrite = 1'b0; In_MemToReg = mr; In_Rs = rs; In_Rt = rt;
    In_WriteReg = wr; In_RsData = rsd; In_RtData = rtd; In_Imm = imm; In_Shamt = sh;
  endtask

  task automatic drive_fwd(input logic erw, input logic [4:0] ewr, input logic [31:0] eres,
                           input logic mrw, input logic [4:0] mwr, input logic [31:0] mres);
    ExMem_RegWrite = erw; ExMem_WriteReg = ewr; ExMem_Result = eres;
    MemWb_RegWrite = mrw; MemWb_WriteReg = mwr; MemWb_Result = mres;
  endtask

  function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] d);
    if (ExMem_RegWrite && ExMem_WriteReg == r && r != 5'd0) return ExMem_Result;
    if (MemWb_RegWrite && MemWb_WriteReg == r && r != 5'd0) return MemWb_Result;
    return d;
  endfunction

  initial begin
    logic [5:0] ops [9];
    ops = '{6'd0, 6'd2, 6'd8, 6'd9, 6'd11, 6'd16, 6'd17, 6'd18, 6'd38};
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive_instr(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick(); tick();
    push_exp(0); push_exp(0); push_exp(0); push_exp(0); push_exp(0); push_exp(0);
    pop_chk("rst_a", A); pop_chk("rst_b", B); pop_chk("rst_ctl", {26'd0, ALUControl});
    pop_chk("rst_valid", {31'd0, Out_Valid}); pop_chk("rst_rw", {31'd0, Out_RegWrite});
    pop_chk("rst_hazard", {31'd0, Hazard});
    Reset = 1'b0;

    // basic ADD
    drive_instr(1'b1, 6'd2, 1'b0, 1'b1, 1'b0, 5'd8, 5'd9, 5'd10, 32'd5, 32'd7, 32'd0, 5'd0);
    push_exp(5); push_exp(7); push_exp(2); push_exp(1); push_exp(10);
    tick();
    pop_chk("add_a", A); pop_chk("add_b", B); pop_chk("add_ctl", {26'd0, ALUControl});
    pop_chk("add_valid", {31'd0, Out_Valid}); pop_chk("add_wr", {27'd0, Out_WriteReg});

    // forwarding priority while held
    Stall = 1'b1;
    drive_fwd(1'b1, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22);
    push_exp(32'h11); #1 pop_chk("fwd_exmem", A);
    ExMem_RegWrite = 1'b0;
    push_exp(32'h22); #1 pop_chk("fwd_memwb", A);
    MemWb_RegWrite = 1'b0;
    push_exp(5); #1 pop_chk("fwd_none", A);
    Stall = 1'b0;

    // register zero never forwarded
    drive_instr(1'b1, 6'd2, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    drive_fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    push_exp(0); push_exp(0); #1 pop_chk("r0_a", A); pop_chk("r0_sd", Out_StoreData);
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // random operand / forwarding patterns
    for (int i = 0; i < 10; i++) begin
      logic [5:0]  op;
      logic [4:0]  rs, rt, sh;
      logic [31:0] rsd, rtd, imm;
      logic        alusrc;
      op = ops[$urandom_range(0, 8)];
      rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
      sh = 5'($urandom_range(0, 31)); alusrc = 1'($urandom_range(0, 1));
      rsd = $urandom; rtd = $urandom; imm = $urandom;
      drive_instr(1'b1, op, alusrc, 1'b1, 1'b0, rs, rt, 5'd4, rsd, rtd, imm, sh);
      tick();
      drive_fwd(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? rs : rt, $urandom,
                1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? rt : rs, $urandom);
      push_exp((op == 6'd8 || op == 6'd9 || op == 6'd11) ? {27'd0, sh} : model_fwd(rs, rsd));
      push_exp(alusrc ? imm : model_fwd(rt, rtd));
      push_exp(model_fwd(rt, rtd));
      #1 pop_chk("rnd_a", A); pop_chk("rnd_b", B); pop_chk("rnd_sd", Out_StoreData);
    end
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // load-use: one bubble, then consumer with MEM/WB forwarded operand
    drive_instr(1'b1, 6'd2, 1'b0, 1'b1, 1'b1, 5'd4, 5'd0, 5'd3, 32'd100, 32'd0, 32'd8, 5'd0);
    tick();
    drive_instr(1'b1, 6'd2, 1'b0, 1'b1, 1'b0, 5'd5, 5'd3, 5'd6, 32'd1, 32'd0, 32'd0, 5'd0);
    push_exp(1); #1 pop_chk("lu_hazard", {31'd0, Hazard});
    tick();
    push_exp(0); push_exp(0); push_exp(0);
    pop_chk("lu_bub_valid", {31'd0, Out_Valid}); pop_chk("lu_bub_rw", {31'd0, Out_RegWrite});
    pop_chk("lu_hazard_clr", {31'd0, Hazard});
    tick();
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    push_exp(1); push_exp(6); push_exp(32'h33);
    #1 pop_chk("lu_cons_valid", {31'd0, Out_Valid}); pop_chk("lu_cons_wr", {27'd0, Out_WriteReg});
    pop_chk("lu_cons_b", B);
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // flush together with hazard
    drive_instr(1'b1, 6'd2, 1'b0, 1'b1, 1'b1, 5'd4, 5'd0, 5'd3, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    drive_instr(1'b1, 6'd2, 1'b0, 1'b1, 1'b0, 5'd3, 5'd7, 5'd9, 32'd0, 32'd0, 32'd0, 5'd0);
    Flush = 1'b1;
    push_exp(1); #1 pop_chk("fh_hazard", {31'd0, Hazard});
    tick();
    Flush = 1'b0;
    push_exp(0); push_exp(0); #1 pop_chk("fh_valid", {31'd0, Out_Valid});
    pop_chk("fh_hazard_clr", {31'd0, Hazard});
    tick();
    push_exp(1); push_exp(9); pop_chk("fh_cons_valid", {31'd0, Out_Valid});
    pop_chk("fh_cons_wr", {27'd0, Out_WriteReg});

    // SLL shamt select, then stall refresh of held rt
    drive_instr(1'b1, 6'd8, 1'b0, 1'b1, 1'b0, 5'd7, 5'd2, 5'd12, 32'h99, 32'h10, 32'd0, 5'd4);
    tick();
    push_exp(4); push_exp(32'h10); pop_chk("sll_a", A); pop_chk("sll_b", B);
    Stall = 1'b1;
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h77);
    push_exp(32'h77); #1 pop_chk("stall_fwd_b", B);
    tick();
    MemWb_RegWrite = 1'b0;
    push_exp(32'h77); #1 pop_chk("stall_keep_b1", B);
    tick();
    push_exp(32'h77); push_exp(32'h77); pop_chk("stall_keep_b2", B);
    pop_chk("stall_keep_sd", Out_StoreData);
    tick();
    push_exp(4); push_exp(1); pop_chk("stall_hold_a", A); pop_chk("stall_hold_valid", {31'd0, Out_Valid});

    // flush wins over stall
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    push_exp(0); push_exp(0); push_exp(0);
    pop_chk("fs_valid", {31'd0, Out_Valid}); pop_chk("fs_ctl", {26'd0, ALUControl});
    pop_chk("fs_a", A);
    Stall = 1'b0;

    // reset mid-stall
    drive_instr(1'b1, 6'd2, 1'b1, 1'b1, 1'b0, 5'd8, 5'd9, 5'd10, 32'h5, 32'h6, 32'h7, 5'd3);
    tick();
    Stall = 1'b1;
    tick();
    Reset = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) push_exp(0);
    pop_chk("rs_a", A); pop_chk("rs_b", B); pop_chk("rs_sd", Out_StoreData);
    pop_chk("rs_ctl", {26'd0, ALUControl}); pop_chk("rs_valid", {31'd0, Out_Valid});
    pop_chk("rs_rw", {31'd0, Out_RegWrite}); pop_chk("rs_wr", {27'd0, Out_WriteReg});
    Reset = 1'b0; Stall = 1'b0;

    check("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
